display_buffer: RTL
===================

DISPLAY_BUFFER -- requirements
Module: display_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of character cells (minimum 2).
REQ-002 SHALL have parameter DATA_W, default 8, character width in bits.
REQ-003 SHALL have parameter CARET_CHR, default 8'h5F, glyph substituted at the cursor cell during the caret-visible phase.
REQ-004 SHALL have parameter BLANK_CHR, default 8'h20, fill glyph for reset, clear and backspace.
REQ-005 SHALL have parameter BLINK_DIV, default 6000000, clock cycles per caret blink half-period (minimum 1); derived localparam ADDR_W = max(1, clog2(DEPTH)).
REQ-006 SHALL have port i_clk  input  1  sole clock; all state on its rising edge.
REQ-007 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port i_wr_valid  input  1  append i_wr_data at the cursor.
REQ-009 SHALL have port i_wr_data  input  DATA_W  character to append.
REQ-010 SHALL have port i_bs  input  1  backspace command.
REQ-011 SHALL have port i_clr  input  1  clear-screen command.
REQ-012 SHALL have port i_rd_en  input  1  read strobe.
REQ-013 SHALL have port i_rd_addr  input  ADDR_W  cell to read.
REQ-014 SHALL have port o_rd_data  output  DATA_W  registered read data with caret overlay.
REQ-015 SHALL have port o_cursor  output  ADDR_W  current cursor cell.
REQ-016 SHALL have port o_full  output  1  all cells written; the next write scrolls.
REQ-017 SHALL have port o_busy  output  1  clear sweep in progress.

Function
REQ-018 SHALL accept at most one command per cycle, priority i_clr > i_bs > i_wr_valid; lower-priority commands in the same cycle are dropped.
REQ-019 SHALL ignore all commands while o_busy=1.
REQ-020 SHALL, on a write with o_full=0 and cursor<DEPTH-1: set mem[cursor]<=data and cursor<=cursor+1.
REQ-021 SHALL, on a write with o_full=0 and cursor=DEPTH-1: set mem[DEPTH-1]<=data, set o_full=1, and hold the cursor.
REQ-022 SHALL, on a write with o_full=1: scroll in one cycle, mem[i]<=mem[i+1] for i<DEPTH-1 and mem[DEPTH-1]<=data; cursor stays DEPTH-1 and o_full stays 1.
REQ-023 SHALL, on a backspace with o_full=1: set mem[DEPTH-1]<=BLANK_CHR and o_full<=0, holding the cursor.
REQ-024 SHALL, on a backspace with o_full=0 and cursor>0: set cursor<=cursor-1 and mem[cursor-1]<=BLANK_CHR.
REQ-025 SHALL treat a backspace with o_full=0 and cursor=0 as a no-op.
REQ-026 SHALL, on an accepted clear: in the next cycle set cursor=0, o_full=0 and o_busy=1; then write BLANK_CHR to cells 0..DEPTH-1, one per cycle, in ascending order; deassert o_busy in the cycle after cell DEPTH-1 is written (busy for exactly DEPTH cycles).
REQ-027 SHALL register o_rd_data one cycle after i_rd_en=1 and hold it while i_rd_en=0.
REQ-028 SHALL return CARET_CHR when i_rd_addr equals the cursor and blink phase=0; otherwise it SHALL return mem[i_rd_addr].
REQ-029 SHALL return BLANK_CHR for i_rd_addr>=DEPTH.
REQ-030 SHALL make reads return pre-update contents when a same-cycle write, backspace or clear step modifies the addressed cell.
REQ-031 SHALL permit reads during a clear sweep, with the overlay at cursor 0.
REQ-032 SHALL run a blink counter 0..BLINK_DIV-1 that toggles the phase at its terminal count and wraps to 0.
REQ-033 SHALL zero the counter and force phase=0 on every accepted write or backspace, so the caret is visible immediately.

Reset
REQ-034 SHALL, while i_rst_n=0, asynchronously set: all cells=BLANK_CHR, cursor=0, o_full=0, o_busy=0, o_rd_data=0, blink counter=0, phase=0.
REQ-035 SHALL abort an in-progress clear sweep on reset, leaving state exactly as in REQ-034.

Verification
REQ-036 SHALL pass fill-and-scroll (DEPTH=4, large BLINK_DIV): write 41,42,43,44,45 -> mem=42,43,44,45; cursor=3; o_full=1 after the 4th write.
REQ-037 SHALL pass backspace at bounds: after 41,42, issue 3 backspaces -> cursor 2,1,0,0; cells 0-1=20; the third backspace changes nothing.
REQ-038 SHALL pass caret blink (BLINK_DIV=4): idle reads of the cursor cell -> 5F for 4 cycles, then the cell content for 4 cycles, repeating; a write restarts at 5F.
REQ-039 SHALL pass clear with contention: clear while full -> o_busy high exactly 4 cycles; writes during busy are ignored; all cells=20; cursor=0.
REQ-040 SHALL pass priority: i_clr, i_bs and i_wr_valid in the same cycle -> only the clear executes.
REQ-041 SHALL pass reset mid-clear: assert i_rst_n=0 during sweep cycle 2 -> all outputs take reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/display_buffer.sv
// display_buffer: character line buffer with append/backspace/clear, one-cycle scroll,
// registered reads and a blinking caret overlay at the cursor cell.
`default_nettype none

module display_buffer #(
  parameter int                DEPTH     = 16,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] CARET_CHR = DATA_W'(8'h5F),
  parameter logic [DATA_W-1:0] BLANK_CHR = DATA_W'(8'h20),
  parameter int                BLINK_DIV = 6000000,
  localparam int               ADDR_W    = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_bs,
  input  logic              i_clr,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W-1:0] o_cursor,
  output logic              o_full,
  output logic              o_busy
);

  localparam int                CNT_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [ADDR_W-1:0] c_last    = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  c_cnt_max = CNT_W'(BLINK_DIV - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_cursor;
  logic [ADDR_W-1:0] r_clr_idx;
  logic              r_full;
  logic              r_busy;
  logic [DATA_W-1:0] r_rd_data;
  logic [CNT_W-1:0]  r_blink_cnt;
  logic              r_phase;

  logic w_do_clr;
  logic w_do_bs;
  logic w_do_wr;
  logic w_in_range;

  // One command per cycle, clear > backspace > write, nothing while sweeping.
  assign w_do_clr   = !r_busy && i_clr;
  assign w_do_bs    = !r_busy && !i_clr && i_bs;
  assign w_do_wr    = !r_busy && !i_clr && !i_bs && i_wr_valid;
  assign w_in_range = (32'(i_rd_addr) < 32'(DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= BLANK_CHR;
    end else if (w_do_wr && r_full) begin
      for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
      r_mem[DEPTH-1] <= i_wr_data;
    end else if (w_do_wr) begin
      r_mem[r_cursor] <= i_wr_data;
    end else if (w_do_bs) begin
      if (r_full) r_mem[DEPTH-1] <= BLANK_CHR;
      else if (r_cursor != '0) r_mem[r_cursor - 1'b1] <= BLANK_CHR;
    end else if (r_busy) begin
      r_mem[r_clr_idx] <= BLANK_CHR;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cursor  <= '0;
      r_full    <= 1'b0;
      r_busy    <= 1'b0;
      r_clr_idx <= '0;
    end else if (w_do_clr) begin
      r_cursor  <= '0;
      r_full    <= 1'b0;
      r_busy    <= 1'b1;
      r_clr_idx <= '0;
    end else if (w_do_bs) begin
      // Backspacing a full line only un-fills it; the cursor already sits on the last cell.
      if (r_full) r_full <= 1'b0;
      else if (r_cursor != '0) r_cursor <= r_cursor - 1'b1;
    end else if (w_do_wr) begin
      if (!r_full) begin
        if (r_cursor == c_last) r_full <= 1'b1;
        else r_cursor <= r_cursor + 1'b1;
      end
    end else if (r_busy) begin
      if (r_clr_idx == c_last) r_busy <= 1'b0;
      else r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_do_wr || w_do_bs) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == c_cnt_max) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      if (!w_in_range) r_rd_data <= BLANK_CHR;
      else if ((i_rd_addr == r_cursor) && !r_phase) r_rd_data <= CARET_CHR;
      else r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_cursor  = r_cursor;
  assign o_full    = r_full;
  assign o_busy    = r_busy;

endmodule

`default_nettype wire
